send_results: RTL and testbench
===============================

Name: send_results

Overview:
- Streams the correlator result bank to the host over the UART transmitter, one byte at a time.
- Sits downstream of the master control FSM, which pulses send_start and then polls send_busy; its byte stream and start strobe are routed through the UART source mux.
- Reads results from the correlator result memory by address, serialises each result MSB-first, brackets the payload with a sync header and an XOR checksum, then returns to idle.

Parameters:
NUM_LAGS, 32, number of correlator results (lags) in one frame
RESULT_W, 32, bits per result word; must be a multiple of 8
ADDR_W, 5, result address width; 2**ADDR_W >= NUM_LAGS
SYNC_BYTE, 8'hA5, frame header byte

Ports:
sys_clk  in  1  system clock
sys_rst  in  1  reset, asynchronous, active-high
send_start  in  1  one-cycle start pulse from master FSM
uart_busy  in  1  UART transmitter busy; high while a byte is shifting out
res_data  in  RESULT_W  result word; valid exactly one cycle after res_rd
res_rd  out  1  result memory read strobe, one cycle wide
res_addr  out  ADDR_W  result memory address (lag index)
tx_data  out  8  byte presented to the UART; stable from the start_uart_tx cycle until uart_busy falls
start_uart_tx  out  1  one-cycle transmit request to the UART
send_busy  out  1  high whenever the block is not IDLE

Behaviour:
- Reset (async): state IDLE; res_rd=0, res_addr=0, tx_data=0, start_uart_tx=0, send_busy=0, checksum=0, byte index=0.
- send_busy = (state != IDLE), registered state only. It is high in the cycle immediately after the send_start cycle; the master FSM depends on this.
- Frame byte order: SYNC_BYTE; then for lag 0..NUM_LAGS-1 the RESULT_W/8 bytes of the result, MSB first; then CHK = XOR of all payload bytes (header excluded). Defaults give 1+128+1 = 130 bytes.
- States and transitions:
  - IDLE: on send_start, go to HDR; clear checksum, lag counter and byte counter.
  - HDR: load tx_data=SYNC_BYTE and go to TX.
  - RD: res_rd=1 for one cycle at res_addr=lag; go to LD.
  - LD: capture res_data into the shift register; go to BYTE.
  - BYTE: tx_data = shift register top byte; checksum ^= that byte; go to TX.
  - TX: start_uart_tx=1 for exactly one cycle, only entered while uart_busy=0; go to WAIT_HI.
  - WAIT_HI: stay until uart_busy=1, then go to WAIT_LO.
  - WAIT_LO: stay until uart_busy=0, then go to NEXT.
  - NEXT: select what follows the byte just sent:
    - header just sent → RD;
    - payload byte with more bytes left in the word → shift left by 8, BYTE;
    - last byte of a word with lag < NUM_LAGS-1 → lag+1, RD;
    - last byte of the last word → CHKS;
    - checksum just sent → IDLE.
  - CHKS: tx_data = checksum; go to TX.
- TX entry guard: if uart_busy is already high when TX would be entered (for example, connection-ack byte still in flight), hold in a PRE_TX wait until uart_busy=0. No start pulse is issued while uart_busy=1.
- send_start while not IDLE: ignored; the frame in progress is not restarted.
- res_addr holds its value between reads. After a frame it rests at NUM_LAGS-1. It is cleared on the next send_start.
- sys_rst mid-frame: aborts immediately to IDLE with all outputs at reset values. A byte already in the UART completes there; this block must not re-pulse start_uart_tx.
- Checksum and counters wrap naturally; the lag counter is sized ADDR_W and never exceeds NUM_LAGS-1.

Decomposition:
- Shared package/header: state encodings, SYNC_BYTE, and BYTES_PER_RESULT = RESULT_W/8 as a localparam constant.
- One natural sub-module: uart_byte_handshake. It owns PRE_TX/TX/WAIT_HI/WAIT_LO.
  - Interface: byte_req in, byte_done out, start_uart_tx out, uart_busy in.
  - The top FSM then only sequences bytes.

Test Plan:
1. Normal frame: results[i] = 32'h01020304 + i, UART model busy for 10 cycles starting 1 cycle after each start pulse, pulse send_start.
   - Exactly 130 start_uart_tx pulses.
   - Bytes: A5, 01 02 03 04, 01 02 03 05, …
   - Final byte equals the XOR of the 128 payload bytes.
   - send_busy falls after the last uart_busy fall.
2. send_busy timing: pulse send_start at cycle N → send_busy=1 at cycle N+1 and stays high until the frame ends.
3. UART already busy: hold uart_busy=1 for 20 cycles when send_start arrives → no start_uart_tx until uart_busy falls; header is still A5.
4. Slow busy rise: the UART raises busy 3 cycles after the start pulse → the block waits in WAIT_HI and issues no duplicate pulse; byte count stays 130.
5. Abort: assert sys_rst asynchronously at byte 40 → all outputs reset immediately. A subsequent send_start produces a full fresh 130-byte frame starting at res_addr=0 with a correct checksum.
6. Ignored restart: pulse send_start again at byte 60 → frame unaffected, total 130 bytes, checksum unchanged.

Source files
------------

// File: rtl/send_results_pkg.sv
// Shared types and constants for the result-bank streamer: state encodings,
// frame header byte and result word geometry.
package send_results_pkg;

  localparam int NUM_LAGS_DEF     = 32;
  localparam int RESULT_W_DEF     = 32;
  localparam int ADDR_W_DEF       = 5;
  localparam int BYTES_PER_RESULT = RESULT_W_DEF / 8;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // Byte sequencer states; the UART handshake lives in its own FSM.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_RD   = 3'd2,
    ST_LD   = 3'd3,
    ST_BYTE = 3'd4,
    ST_SEND = 3'd5,
    ST_NEXT = 3'd6,
    ST_CHKS = 3'd7
  } send_state_e;

  typedef enum logic [2:0] {
    HS_IDLE    = 3'd0,
    HS_PRE_TX  = 3'd1,
    HS_TX      = 3'd2,
    HS_WAIT_HI = 3'd3,
    HS_WAIT_LO = 3'd4
  } hs_state_e;

  // Which part of the frame the byte in flight belongs to.
  typedef enum logic [1:0] {
    PH_HDR = 2'd0,
    PH_PAY = 2'd1,
    PH_CHK = 2'd2
  } phase_e;

  function automatic logic [7:0] chk_update(input logic [7:0] chk, input logic [7:0] b);
    return chk ^ b;
  endfunction

endpackage

// File: rtl/send_results_if.sv
// Bundle of the master-FSM handshake, result-memory read port and UART byte port.
interface send_results_if #(
  parameter int RESULT_W = 32,
  parameter int ADDR_W   = 5
);
  logic                send_start;
  logic                send_busy;
  logic                res_rd;
  logic [ADDR_W-1:0]   res_addr;
  logic [RESULT_W-1:0] res_data;
  logic [7:0]          tx_data;
  logic                start_uart_tx;
  logic                uart_busy;

  modport master (
    input  send_start, uart_busy, res_data,
    output send_busy, res_rd, res_addr, tx_data, start_uart_tx
  );

  modport slave (
    output send_start, uart_busy, res_data,
    input  send_busy, res_rd, res_addr, tx_data, start_uart_tx
  );
endinterface

// File: rtl/send_results_uart_byte_handshake.sv
// One-byte UART handshake: waits for an idle UART, pulses the transmit request
// once, then tracks busy high and low before reporting the byte as done.
module uart_byte_handshake
  import send_results_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic byte_req_i,
  input  logic uart_busy_i,
  output logic byte_done_o,
  output logic start_uart_tx_o
);

  hs_state_e hs_state_q;
  logic      start_q;
  logic      done_q;

  // Handshake FSM with registered start and done pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_state_q <= HS_IDLE;
      start_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (hs_state_q)
        HS_IDLE: begin
          done_q <= 1'b0;
          if (byte_req_i) begin
            if (uart_busy_i) begin
              hs_state_q <= HS_PRE_TX;
            end else begin
              start_q    <= 1'b1;
              hs_state_q <= HS_TX;
            end
          end
        end
        HS_PRE_TX: begin
          if (!uart_busy_i) begin
            start_q    <= 1'b1;
            hs_state_q <= HS_TX;
          end
        end
        HS_TX: begin
          start_q    <= 1'b0;
          hs_state_q <= HS_WAIT_HI;
        end
        HS_WAIT_HI: begin
          if (uart_busy_i) begin
            hs_state_q <= HS_WAIT_LO;
          end
        end
        HS_WAIT_LO: begin
          if (!uart_busy_i) begin
            done_q     <= 1'b1;
            hs_state_q <= HS_IDLE;
          end
        end
        default: begin
          start_q    <= 1'b0;
          done_q     <= 1'b0;
          hs_state_q <= HS_IDLE;
        end
      endcase
    end
  end

  assign byte_done_o     = done_q;
  assign start_uart_tx_o = start_q;

endmodule

// File: rtl/send_results.sv
// Streams the correlator result bank to the UART: sync header, every result
// MSB-first, then an XOR checksum of the payload bytes.
module send_results
  import send_results_pkg::*;
#(
  parameter int          NUM_LAGS = NUM_LAGS_DEF,
  parameter int          RESULT_W = BYTES_PER_RESULT * 8,
  parameter int          ADDR_W   = ADDR_W_DEF,
  parameter logic [7:0]  HDR_BYTE = SYNC_BYTE
) (
  input  logic           sys_clk,
  input  logic           sys_rst,
  send_results_if.master bus
);

  localparam int WORD_BYTES = RESULT_W / 8;
  localparam int BIDX_W     = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [ADDR_W-1:0] LAST_LAG  = ADDR_W'(NUM_LAGS - 1);
  localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(WORD_BYTES - 1);

  send_state_e         state_q;
  phase_e              phase_q;
  logic [ADDR_W-1:0]   lag_q;
  logic [BIDX_W-1:0]   bidx_q;
  logic [RESULT_W-1:0] shift_q;
  logic [7:0]          chk_q;
  logic [7:0]          tx_data_q;
  logic                res_rd_q;
  logic [ADDR_W-1:0]   res_addr_q;
  logic                send_busy_q;
  logic                byte_req_q;

  logic                byte_done_s;
  logic                start_uart_tx_s;
  logic [7:0]          top_byte_d;
  logic [7:0]          chk_d;
  logic [RESULT_W-1:0] shift_d;
  logic [ADDR_W-1:0]   lag_d;

  // Datapath helpers for the next byte, checksum and lag.
  always_comb begin
    top_byte_d = shift_q[RESULT_W-1 -: 8];
    chk_d      = chk_update(chk_q, top_byte_d);
    shift_d    = {shift_q[RESULT_W-9:0], 8'h00};
    lag_d      = lag_q + {{(ADDR_W-1){1'b0}}, 1'b1};
  end

  // Byte sequencer; res_rd and res_addr are set on entry to RD so the strobe
  // is live during RD and the word is back for LD to capture.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= ST_IDLE;
      phase_q     <= PH_HDR;
      lag_q       <= '0;
      bidx_q      <= '0;
      shift_q     <= '0;
      chk_q       <= 8'h00;
      tx_data_q   <= 8'h00;
      res_rd_q    <= 1'b0;
      res_addr_q  <= '0;
      send_busy_q <= 1'b0;
      byte_req_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          res_rd_q   <= 1'b0;
          byte_req_q <= 1'b0;
          if (bus.send_start) begin
            chk_q       <= 8'h00;
            lag_q       <= '0;
            bidx_q      <= '0;
            res_addr_q  <= '0;
            phase_q     <= PH_HDR;
            send_busy_q <= 1'b1;
            state_q     <= ST_HDR;
          end
        end
        ST_HDR: begin
          tx_data_q  <= HDR_BYTE;
          byte_req_q <= 1'b1;
          state_q    <= ST_SEND;
        end
        ST_RD: begin
          res_rd_q <= 1'b0;
          state_q  <= ST_LD;
        end
        ST_LD: begin
          shift_q <= bus.res_data;
          bidx_q  <= '0;
          state_q <= ST_BYTE;
        end
        ST_BYTE: begin
          tx_data_q  <= top_byte_d;
          chk_q      <= chk_d;
          byte_req_q <= 1'b1;
          state_q    <= ST_SEND;
        end
        ST_SEND: begin
          byte_req_q <= 1'b0;
          if (byte_done_s) begin
            state_q <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          case (phase_q)
            PH_HDR: begin
              phase_q    <= PH_PAY;
              res_addr_q <= lag_q;
              res_rd_q   <= 1'b1;
              state_q    <= ST_RD;
            end
            PH_PAY: begin
              if (bidx_q != LAST_BYTE) begin
                shift_q <= shift_d;
                bidx_q  <= bidx_q + {{(BIDX_W-1){1'b0}}, 1'b1};
                state_q <= ST_BYTE;
              end else if (lag_q != LAST_LAG) begin
                lag_q      <= lag_d;
                res_addr_q <= lag_d;
                res_rd_q   <= 1'b1;
                state_q    <= ST_RD;
              end else begin
                phase_q <= PH_CHK;
                state_q <= ST_CHKS;
              end
            end
            PH_CHK: begin
              send_busy_q <= 1'b0;
              state_q     <= ST_IDLE;
            end
            default: begin
              send_busy_q <= 1'b0;
              state_q     <= ST_IDLE;
            end
          endcase
        end
        ST_CHKS: begin
          tx_data_q  <= chk_q;
          byte_req_q <= 1'b1;
          state_q    <= ST_SEND;
        end
        default: begin
          res_rd_q    <= 1'b0;
          byte_req_q  <= 1'b0;
          send_busy_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  uart_byte_handshake u_hs (
    .clk             (sys_clk),
    .rst             (sys_rst),
    .byte_req_i      (byte_req_q),
    .uart_busy_i     (bus.uart_busy),
    .byte_done_o     (byte_done_s),
    .start_uart_tx_o (start_uart_tx_s)
  );

  assign bus.send_busy     = send_busy_q;
  assign bus.res_rd        = res_rd_q;
  assign bus.res_addr      = res_addr_q;
  assign bus.tx_data       = tx_data_q;
  assign bus.start_uart_tx = start_uart_tx_s;

endmodule

// File: tb/tb_send_results.sv
// Directed bench for send_results: result memory and UART behavioural models
// around the DUT, frames compared byte-for-byte against bench-computed values.
module tb_send_results;
  import send_results_pkg::*;

  localparam int NL    = 32;
  localparam int FRAME = 130;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic ext_busy = 1'b0;
  logic m_busy = 1'b0;

  send_results_if #(.RESULT_W(32), .ADDR_W(5)) bus ();

  send_results #(.NUM_LAGS(NL), .RESULT_W(32), .ADDR_W(5)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  logic [31:0] mem [NL];
  int          cyc = 0;
  int          rise_dly = 1;
  int          wait_cnt = 0;
  int          busy_cnt = 0;
  int          dup_err = 0;
  int          stab_err = 0;
  int          last_fall_cyc = 0;
  logic [7:0]  cur_byte = 8'h00;
  logic [7:0]  got_q [$];
  logic [4:0]  rd_addr_q [$];
  int          n_vec = 0;
  int          n_err = 0;

  assign bus.uart_busy = m_busy | ext_busy;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Result memory: data returns one cycle after the read strobe.
  always @(posedge sys_clk) begin
    if (bus.res_rd) begin
      bus.res_data <= mem[bus.res_addr];
      rd_addr_q.push_back(bus.res_addr);
    end
  end

  // UART model: busy rises rise_dly cycles after a start pulse, lasts 10 cycles.
  always @(posedge sys_clk) begin
    if (bus.start_uart_tx) begin
      if (bus.uart_busy) dup_err <= dup_err + 1;
      got_q.push_back(bus.tx_data);
      cur_byte <= bus.tx_data;
      wait_cnt <= rise_dly;
    end else if (wait_cnt > 0) begin
      if (wait_cnt == 1) begin
        m_busy   <= 1'b1;
        busy_cnt <= 10;
      end
      wait_cnt <= wait_cnt - 1;
    end else if (busy_cnt > 0) begin
      if (busy_cnt == 1) begin
        m_busy        <= 1'b0;
        last_fall_cyc <= cyc;
      end
      busy_cnt <= busy_cnt - 1;
    end
    if (m_busy && !sys_rst && bus.tx_data != cur_byte) stab_err <= stab_err + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic set_pattern(input int sel);
    for (int i = 0; i < NL; i++) begin
      if (sel == 0) mem[i] = 32'h01020304 + 32'(i);
      else          mem[i] = 32'(32'h9E3779B9 * 32'(i + 1));
    end
  endtask

  function automatic logic [7:0] exp_chk();
    logic [7:0]  c;
    logic [31:0] w;
    c = 8'h00;
    for (int i = 0; i < NL; i++) begin
      w = mem[i];
      c = c ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
    end
    return c;
  endfunction

  function automatic logic [7:0] exp_byte(input int k);
    logic [31:0] w;
    if (k == 0) return SYNC_BYTE;
    if (k == FRAME - 1) return exp_chk();
    w = mem[(k - 1) / 4];
    return w[8 * (3 - ((k - 1) % 4)) +: 8];
  endfunction

  task automatic wait_idle(input string tag, output int fall_cyc);
    int n;
    n = 0;
    while (bus.send_busy && n < 6000) begin
      tick;
      n++;
    end
    check_eq({tag, "_timeout"}, 32'(n < 6000), 32'd1);
    fall_cyc = cyc;
  endtask

  task automatic wait_bytes(input string tag, input int base, input int cnt);
    int n;
    n = 0;
    while (got_q.size() - base < cnt && n < 4000) begin
      tick;
      n++;
    end
    check_eq({tag, "_timeout"}, 32'(n < 4000), 32'd1);
  endtask

  task automatic check_frame(input string tag, input int base);
    int sz;
    int bad;
    sz  = got_q.size() - base;
    bad = 0;
    check_eq({tag, "_count"}, 32'(sz), 32'(FRAME));
    for (int k = 0; k < FRAME && k < sz; k++) begin
      if (got_q[base + k] !== exp_byte(k)) bad++;
    end
    check_eq({tag, "_bytes_bad"}, 32'(bad), 32'd0);
    if (sz > 0) check_eq({tag, "_hdr"}, 32'(got_q[base]), 32'h0000_00A5);
    if (sz >= FRAME) check_eq({tag, "_chk"}, 32'(got_q[base + FRAME - 1]), 32'(exp_chk()));
  endtask

  task automatic pulse_start;
    bus.send_start = 1'b1;
    tick;
    bus.send_start = 1'b0;
  endtask

  task automatic check_outputs_reset(input string tag);
    check_eq({tag, "_res_rd"}, 32'(bus.res_rd), 32'd0);
    check_eq({tag, "_res_addr"}, 32'(bus.res_addr), 32'd0);
    check_eq({tag, "_tx_data"}, 32'(bus.tx_data), 32'd0);
    check_eq({tag, "_start"}, 32'(bus.start_uart_tx), 32'd0);
    check_eq({tag, "_busy"}, 32'(bus.send_busy), 32'd0);
  endtask

  initial begin
    int base, sb, db, rb, fall, n0, n;
    bus.send_start = 1'b0;
    set_pattern(0);
    repeat (3) tick;
    check_outputs_reset("rst");
    sys_rst = 1'b0;
    tick;
    check_outputs_reset("post_rst");

    // Normal frame plus send_busy timing
    base = got_q.size(); sb = stab_err; db = dup_err; rb = rd_addr_q.size();
    check_eq("busy_before_start", 32'(bus.send_busy), 32'd0);
    bus.send_start = 1'b1;
    tick;
    check_eq("busy_next_cycle", 32'(bus.send_busy), 32'd1);
    bus.send_start = 1'b0;
    wait_idle("f1", fall);
    check_frame("f1", base);
    check_eq("f1_b1", 32'(got_q[base + 1]), 32'h01);
    check_eq("f1_b4", 32'(got_q[base + 4]), 32'h04);
    check_eq("f1_b8", 32'(got_q[base + 8]), 32'h05);
    check_eq("f1_chk_hand", 32'(got_q[base + FRAME - 1]), 32'h00);
    check_eq("f1_busy_after_uart", 32'(fall > last_fall_cyc + 1), 32'd1);
    check_eq("f1_stable", 32'(stab_err - sb), 32'd0);
    check_eq("f1_dup", 32'(dup_err - db), 32'd0);
    check_eq("f1_reads", 32'(rd_addr_q.size() - rb), 32'(NL));
    check_eq("f1_first_addr", 32'(rd_addr_q[rb]), 32'd0);
    check_eq("f1_addr_rest", 32'(bus.res_addr), 32'(NL - 1));

    // UART already busy at start
    repeat (3) tick;
    base = got_q.size(); db = dup_err;
    ext_busy = 1'b1;
    pulse_start;
    repeat (19) tick;
    check_eq("f3_no_pulse", 32'(got_q.size() - base), 32'd0);
    check_eq("f3_busy_held", 32'(bus.send_busy), 32'd1);
    ext_busy = 1'b0;
    wait_idle("f3", fall);
    check_frame("f3", base);
    check_eq("f3_dup", 32'(dup_err - db), 32'd0);

    // Slow busy rise, different data
    set_pattern(1);
    rise_dly = 3;
    repeat (3) tick;
    base = got_q.size(); db = dup_err; sb = stab_err;
    pulse_start;
    wait_idle("f4", fall);
    check_frame("f4", base);
    check_eq("f4_dup", 32'(dup_err - db), 32'd0);
    check_eq("f4_stable", 32'(stab_err - sb), 32'd0);
    rise_dly = 1;

    // Abort at byte 40, then a fresh frame
    repeat (3) tick;
    base = got_q.size();
    pulse_start;
    wait_bytes("f5_abort", base, 40);
    #3;
    sys_rst = 1'b1;
    #1;
    check_outputs_reset("abort");
    n0 = got_q.size();
    repeat (15) tick;
    check_eq("abort_no_repulse", 32'(got_q.size() - n0), 32'd0);
    sys_rst = 1'b0;
    n = 0;
    while (bus.uart_busy && n < 100) begin
      tick;
      n++;
    end
    tick;
    check_eq("abort_quiet", 32'(got_q.size() - n0), 32'd0);
    base = got_q.size(); rb = rd_addr_q.size();
    pulse_start;
    wait_idle("f5", fall);
    check_frame("f5", base);
    check_eq("f5_first_addr", 32'(rd_addr_q[rb]), 32'd0);

    // Restart attempt mid-frame is ignored
    repeat (3) tick;
    base = got_q.size(); rb = rd_addr_q.size();
    pulse_start;
    wait_bytes("f6_mid", base, 60);
    pulse_start;
    wait_idle("f6", fall);
    check_frame("f6", base);
    check_eq("f6_reads", 32'(rd_addr_q.size() - rb), 32'(NL));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
